// File: rtl/slon5_pkg.sv
// Shared types and constants for the slon5 block feeder.
package slon5_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned BLOCK_WORDS = 16;

  typedef logic [WORD_WIDTH-1:0]             Word_t;
  typedef logic [BLOCK_WORDS*WORD_WIDTH-1:0] Block_t;

  typedef enum logic [2:0] {
    StFill,
    StMark,
    StZero,
    StLen,
    StOut
  } FeederState_t;

  localparam Word_t PAD_MARK = {1'b1, {(WORD_WIDTH-1){1'b0}}};

endpackage

// File: rtl/slon5_feeder.sv
// Packs a word stream into fixed-size blocks for the slon5 core.
// Define SLON5_FEEDER_PAD_EN for marker/zero/length padding; otherwise the tail is zero-filled.
module slon5_feeder
  import slon5_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = slon5_pkg::WORD_WIDTH,
  parameter int unsigned BLOCK_WORDS = slon5_pkg::BLOCK_WORDS
) (
  input  logic                              ref_clk,
  input  logic                              rst,
  input  logic [WORD_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [BLOCK_WORDS*WORD_WIDTH-1:0] blk_data,
  output logic                              blk_valid,
  output logic                              blk_final,
  input  logic                              blk_ready
);

  localparam int unsigned IdxW  = $clog2(BLOCK_WORDS + 1);
  localparam int unsigned SlotW = $clog2(BLOCK_WORDS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(BLOCK_WORDS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  FeederState_t          state;
  logic [WORD_WIDTH-1:0] buf_q [BLOCK_WORDS];
  logic [IdxW-1:0]       idx;
  logic [SlotW-1:0]      slot;
  logic                  accept;
  logic                  last_slot;

  assign slot      = idx[SlotW-1:0];
  assign accept    = in_valid && in_ready;
  assign last_slot = (idx == IdxLast);

`ifdef SLON5_FEEDER_PAD_EN
  localparam logic [IdxW-1:0]       IdxLen = IdxW'(BLOCK_WORDS - 2);
  localparam logic [WORD_WIDTH-1:0] Mark   = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  logic [63:0]             bitlen;
  logic                    pad_pending;
  logic                    len_pending;
  logic [2*WORD_WIDTH-1:0] len_words;

  assign len_words = (2*WORD_WIDTH)'(bitlen);
`endif

  // Word 0 sits in the most significant slot.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      blk_data[(BLOCK_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state     <= StFill;
      idx       <= '0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_final <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) buf_q[i] <= '0;
`ifdef SLON5_FEEDER_PAD_EN
      bitlen      <= '0;
      pad_pending <= 1'b0;
      len_pending <= 1'b0;
`endif
    end else begin
      unique case (state)
        StFill: begin
          in_ready <= 1'b1;
          if (accept) begin
            buf_q[slot] <= in_data;
            idx         <= idx + IdxOne;
`ifdef SLON5_FEEDER_PAD_EN
            bitlen <= bitlen + 64'(WORD_WIDTH);
`endif
            if (last_slot) begin
              state     <= StOut;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
`ifdef SLON5_FEEDER_PAD_EN
              blk_final   <= 1'b0;
              pad_pending <= in_last;
`else
              blk_final <= in_last;
`endif
            end else if (in_last) begin
              in_ready <= 1'b0;
`ifdef SLON5_FEEDER_PAD_EN
              state <= StMark;
`else
              state <= StZero;
`endif
            end
          end
        end

`ifdef SLON5_FEEDER_PAD_EN
        StMark: begin
          buf_q[slot] <= Mark;
          idx         <= idx + IdxOne;
          state       <= StZero;
        end

        StZero: begin
          if (idx > IdxLen) begin
            // Length words do not fit: finish this block, length goes in the next one.
            if (idx <= IdxLast) buf_q[slot] <= '0;
            if (idx >= IdxLast) begin
              state       <= StOut;
              blk_valid   <= 1'b1;
              blk_final   <= 1'b0;
              len_pending <= 1'b1;
            end else begin
              idx <= idx + IdxOne;
            end
          end else if (idx == IdxLen) begin
            state <= StLen;
          end else begin
            buf_q[slot] <= '0;
            idx         <= idx + IdxOne;
          end
        end

        StLen: begin
          if (idx == IdxLen) begin
            buf_q[slot] <= len_words[2*WORD_WIDTH-1:WORD_WIDTH];
            idx         <= idx + IdxOne;
          end else begin
            buf_q[slot] <= len_words[WORD_WIDTH-1:0];
            state       <= StOut;
            blk_valid   <= 1'b1;
            blk_final   <= 1'b1;
          end
        end
`else
        StZero: begin
          buf_q[slot] <= '0;
          if (last_slot) begin
            state     <= StOut;
            blk_valid <= 1'b1;
            blk_final <= 1'b1;
          end else begin
            idx <= idx + IdxOne;
          end
        end
`endif

        StOut: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_final <= 1'b0;
            idx       <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) buf_q[i] <= '0;
`ifdef SLON5_FEEDER_PAD_EN
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
            if (pad_pending) begin
              state <= StMark;
            end else if (len_pending) begin
              state <= StZero;
            end else begin
              state    <= StFill;
              in_ready <= 1'b1;
              if (blk_final) bitlen <= '0;
            end
`else
            state    <= StFill;
            in_ready <= 1'b1;
`endif
          end
        end

        default: state <= StFill;
      endcase
    end
  end

endmodule
